lcd_responder: RTL

Synthesizable model of a 16x2 HD44780-style character display: the receiving end of the `e`/`rs`/`rw`/`data` bus driven by the team's LCD controller. It synchronizes the bus into `clk`, executes commands and data writes on each falling edge of `e`, and answers status and data reads. It holds display RAM and a scan read port for an on-board renderer and for bench checking of LCD driver blocks.

---
 rtl/lcd_responder_if.sv | 19 +
 rtl/lcd_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_responder_if.sv
// lcd_responder_if: host-side LCD bus between an LCD controller (master) and
// the lcd_responder display model (slave).
//   e        : enable strobe, host -> display, asynchronous to the display clock
//   rs       : 0 = command/status, 1 = data
//   rw       : 0 = write, 1 = read
//   data     : byte driven by the host
//   data_out : read response byte (0 when data_oe = 0)
//   data_oe  : read response valid
interface lcd_responder_if;
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] data;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (output e, rs, rw, data, input data_out, data_oe);
    modport slave  (input e, rs, rw, data, output data_out, data_oe);
endinterface

// File: rtl/lcd_responder.sv
// lcd_responder: synthesizable 16x2 HD44780-style character display model.
// Synchronizes the host bus into clk, executes commands/data writes on each
// falling edge of e, answers status/data reads and exposes display RAM through
// a registered scan port.
// Ports:
//   clk, reset   : system clock, asynchronous active-low reset
//   bus          : host LCD bus (e, rs, rw, data in; data_out, data_oe out)
//   scan_addr    : cell index {line, column[3:0]}
//   scan_char    : cell contents at scan_addr, one cycle latency
//   cursor_addr  : address counter AC
//   display_on, cursor_on, blink_on, two_line, inc_mode : mode flags
//   busy         : internal busy after a write
//   accept       : one-cycle pulse per executed write
//   err          : sticky, unsupported/invalid command seen
//   overrun      : sticky, write arrived while busy
module lcd_responder #(
    parameter int SHORT_BUSY = 4,
    parameter int LONG_BUSY  = 40   // must cover the 32-cycle clear fill
) (
    input  logic               clk,
    input  logic               reset,
    lcd_responder_if.slave     bus,
    input  logic [4:0]         scan_addr,
    output logic [7:0]         scan_char,
    output logic [6:0]         cursor_addr,
    output logic               display_on,
    output logic               cursor_on,
    output logic               blink_on,
    output logic               two_line,
    output logic               inc_mode,
    output logic               busy,
    output logic               accept,
    output logic               err,
    output logic               overrun
);
    localparam int CW = $clog2(LONG_BUSY + 1);

    // Bus pipe word layout: {e, rs, rw, data[7:0]}
    logic [10:0] s0_r, s1_r, s2_r;
    logic [7:0]  cells_r [0:31];
    logic [7:0]  scan_char_r;
    logic [6:0]  ac_r;
    logic        disp_r, cur_r, blink_r, two_r, inc_r;
    logic        accept_r, err_r, overrun_r;
    logic [CW-1:0] busy_cnt_r;
    logic        fill_active_r;
    logic [4:0]  fill_idx_r;

    logic        busy_s, strobe_s, wr_strobe_s, wr_exec_s, cmd_s, dat_s, rd_step_s;
    logic [4:0]  cell_idx_s;
    logic [6:0]  ac_nxt_s;
    logic        disp_nxt_s, cur_nxt_s, blink_nxt_s, two_nxt_s, inc_nxt_s;
    logic        err_set_s, long_s, fill_start_s;
    logic [7:0]  rd_data_s;
    logic        rd_oe_s;

    // AC step with line wrap: the counter only ever lives in 0x00-0x0F / 0x40-0x4F
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (ac == 7'h0F)      r = 7'h40;
            else if (ac == 7'h4F) r = 7'h00;
            else                  r = ac + 7'd1;
        end else begin
            if (ac == 7'h00)      r = 7'h4F;
            else if (ac == 7'h40) r = 7'h0F;
            else                  r = ac - 7'd1;
        end
        return r;
    endfunction

    assign busy_s      = (busy_cnt_r != '0);
    assign strobe_s    = s2_r[10] & ~s1_r[10];   // falling edge of e seen through the pipe
    assign wr_strobe_s = strobe_s & ~s2_r[8];
    assign wr_exec_s   = wr_strobe_s & ~busy_s;
    assign cmd_s       = wr_exec_s & ~s2_r[9];
    assign dat_s       = wr_exec_s &  s2_r[9];
    assign rd_step_s   = strobe_s & s2_r[8] & s2_r[9];   // data reads step AC even while busy
    assign cell_idx_s  = {ac_r[6], ac_r[3:0]};

    // Three-stage synchronizer for the asynchronous host bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_r <= 11'd0;
            s1_r <= 11'd0;
            s2_r <= 11'd0;
        end else begin
            s0_r <= {bus.e, bus.rs, bus.rw, bus.data};
            s1_r <= s0_r;
            s2_r <= s1_r;
        end
    end

    // Command / data-write decode into next-state values
    always_comb begin
        ac_nxt_s     = ac_r;
        disp_nxt_s   = disp_r;
        cur_nxt_s    = cur_r;
        blink_nxt_s  = blink_r;
        two_nxt_s    = two_r;
        inc_nxt_s    = inc_r;
        err_set_s    = 1'b0;
        long_s       = 1'b0;
        fill_start_s = 1'b0;
        if (cmd_s) begin
            casez (s2_r[7:0])
                8'b1???????: begin
                    ac_nxt_s  = {s2_r[6], 2'b00, s2_r[3:0]};
                    err_set_s = (s2_r[5:4] != 2'b00);
                end
                8'b01??????: err_set_s = 1'b1;           // CGRAM not modelled
                8'b001?????: begin
                    two_nxt_s = s2_r[3];
                    err_set_s = ~s2_r[4];                // only 8-bit mode supported
                end
                8'b0001????: ac_nxt_s = ac_r;            // shift: no-op
                8'b00001???: begin
                    disp_nxt_s  = s2_r[2];
                    cur_nxt_s   = s2_r[1];
                    blink_nxt_s = s2_r[0];
                end
                8'b000001??: inc_nxt_s = s2_r[1];
                8'b0000001?: begin
                    ac_nxt_s = 7'h00;
                    long_s   = 1'b1;
                end
                8'b00000001: begin
                    ac_nxt_s     = 7'h00;
                    inc_nxt_s    = 1'b1;
                    long_s       = 1'b1;
                    fill_start_s = 1'b1;
                end
                default: ac_nxt_s = ac_r;                // 0x00: no-op
            endcase
        end else if (dat_s || rd_step_s) begin
            ac_nxt_s = ac_step(ac_r, inc_r);
        end else begin
            ac_nxt_s = ac_r;
        end
    end

    // Control registers, sticky flags and busy counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ac_r       <= 7'h00;
            disp_r     <= 1'b0;
            cur_r      <= 1'b0;
            blink_r    <= 1'b0;
            two_r      <= 1'b0;
            inc_r      <= 1'b1;
            accept_r   <= 1'b0;
            err_r      <= 1'b0;
            overrun_r  <= 1'b0;
            busy_cnt_r <= '0;
        end else begin
            ac_r      <= ac_nxt_s;
            disp_r    <= disp_nxt_s;
            cur_r     <= cur_nxt_s;
            blink_r   <= blink_nxt_s;
            two_r     <= two_nxt_s;
            inc_r     <= inc_nxt_s;
            accept_r  <= wr_exec_s;
            err_r     <= err_r | err_set_s;
            overrun_r <= overrun_r | (wr_strobe_s & busy_s);
            if (wr_exec_s)
                busy_cnt_r <= long_s ? CW'(LONG_BUSY) : CW'(SHORT_BUSY);
            else if (busy_s)
                busy_cnt_r <= busy_cnt_r - CW'(1);
        end
    end

    // Clear fill sequencer: one cell per cycle starting after the clear executes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_active_r <= 1'b0;
            fill_idx_r    <= 5'd0;
        end else if (fill_start_s) begin
            fill_active_r <= 1'b1;
            fill_idx_r    <= 5'd0;
        end else if (fill_active_r) begin
            fill_active_r <= (fill_idx_r != 5'd31);
            fill_idx_r    <= fill_idx_r + 5'd1;
        end
    end

    // Display RAM and registered scan port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) cells_r[i] <= 8'h20;
            scan_char_r <= 8'h20;
        end else begin
            if (dat_s)
                cells_r[cell_idx_s] <= s2_r[7:0];
            else if (fill_active_r)
                cells_r[fill_idx_r] <= 8'h20;
            scan_char_r <= cells_r[scan_addr];
        end
    end

    // Read response straight from s1 so it tracks e while the host holds it high
    always_comb begin
        rd_oe_s   = 1'b0;
        rd_data_s = 8'h00;
        if (s1_r[10] && s1_r[8]) begin
            rd_oe_s   = 1'b1;
            rd_data_s = s1_r[9] ? cells_r[cell_idx_s] : {busy_s, ac_r};
        end else begin
            rd_oe_s   = 1'b0;
            rd_data_s = 8'h00;
        end
    end

    assign bus.data_out = rd_data_s;
    assign bus.data_oe  = rd_oe_s;
    assign scan_char    = scan_char_r;
    assign cursor_addr  = ac_r;
    assign display_on   = disp_r;
    assign cursor_on    = cur_r;
    assign blink_on     = blink_r;
    assign two_line     = two_r;
    assign inc_mode     = inc_r;
    assign busy         = busy_s;
    assign accept       = accept_r;
    assign err          = err_r;
    assign overrun      = overrun_r;
endmodule
